// File: rtl/dmem_pkg.sv
// Shared constants and state encoding for the cleared, single-cycle data memory.
package dmem_pkg;

    localparam int unsigned DMEM_DATA_W    = 64;
    localparam int unsigned DMEM_ADDR_W    = 64;
    localparam int unsigned DMEM_DEPTH     = 1024;
    localparam int unsigned DMEM_ERR_CNT_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a requester (master) and dmem_pipe (slave).
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              wEn;
    logic              rEn;
    logic [ADDR_W-1:0] Add;
    logic [DATA_W-1:0] M_valA;
    logic              rsp_valid;
    logic [DATA_W-1:0] m_valM;
    logic              dmem_err;

    modport master (
        output req_valid, wEn, rEn, Add, M_valA,
        input  req_ready, rsp_valid, m_valM, dmem_err
    );

    modport slave (
        input  req_valid, wEn, rEn, Add, M_valA,
        output req_ready, rsp_valid, m_valM, dmem_err
    );
endinterface

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one enabled synchronous read port, no reset.
module dmem_array #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/dmem_pipe.sv
// Data memory with a power-on clear sweep, 1-cycle request/response handshake,
// range/enable checking and a saturating error counter.
module dmem_pipe
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W    = DMEM_DATA_W,
    parameter int unsigned ADDR_W    = DMEM_ADDR_W,
    parameter int unsigned DEPTH     = DMEM_DEPTH,
    parameter int unsigned ERR_CNT_W = DMEM_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_if.slave                bus,
    output logic                 init_done,
    output logic [ERR_CNT_W-1:0] err_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    // Wide enough to hold both the full address and DEPTH itself.
    localparam int unsigned CMP_W = (ADDR_W > PTR_W) ? ADDR_W + 1 : PTR_W + 1;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 ready_q, ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 err_q, err_d;
    logic                 sel_rd_q, sel_rd_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

    logic                 accept_c;
    logic                 legal_c;
    logic                 mem_we_c;
    logic [PTR_W-1:0]     mem_waddr_c;
    logic [DATA_W-1:0]    mem_wdata_c;
    logic                 mem_re_c;
    logic [PTR_W-1:0]     mem_raddr_c;
    logic [DATA_W-1:0]    rd_data;

    assign accept_c = bus.req_valid & ready_q;
    assign legal_c  = (bus.wEn ^ bus.rEn) && (CMP_W'(bus.Add) < CMP_W'(DEPTH));

    // Next-state, write-port mux and response decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        sel_rd_d    = sel_rd_q;
        cnt_d       = cnt_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = ptr_q;
        mem_wdata_c = '0;
        mem_re_c    = 1'b0;
        mem_raddr_c = PTR_W'(bus.Add);

        case (state_q)
            CLEAR: begin
                mem_we_c = 1'b1;
                ptr_d    = ptr_q + 1'b1;
                if (ptr_q == PTR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            IDLE: begin
                if (accept_c) begin
                    rsp_valid_d = 1'b1;
                    if (legal_c) begin
                        if (bus.wEn) begin
                            mem_we_c    = 1'b1;
                            mem_waddr_c = PTR_W'(bus.Add);
                            mem_wdata_c = bus.M_valA;
                        end else begin
                            mem_re_c = 1'b1;
                            sel_rd_d = 1'b1;
                        end
                    end else begin
                        err_d    = 1'b1;
                        sel_rd_d = 1'b0;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            sel_rd_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            sel_rd_q    <= sel_rd_d;
            cnt_q       <= cnt_d;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_c),
        .waddr (mem_waddr_c),
        .wdata (mem_wdata_c),
        .re    (mem_re_c),
        .raddr (mem_raddr_c),
        .rdata (rd_data)
    );

    // Read data only surfaces after a legal read; errors and reset force zero.
    assign bus.m_valM    = sel_rd_q ? rd_data : '0;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.dmem_err  = err_q;
    assign init_done     = ready_q;
    assign err_count     = cnt_q;
endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe (DEPTH=16); a second instance with a 2-bit error counter shares the stimulus.
module tb_dmem_pipe;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        int          due;
        logic        err;
        logic [63:0] data;
        logic [7:0]  c8;
        logic [1:0]  c2;
    } exp_t;

    logic clk;
    logic rst_n;
    logic init_done, init_done2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    dmem_if #(.DATA_W(64), .ADDR_W(64)) bus ();
    dmem_if #(.DATA_W(64), .ADDR_W(64)) bus2 ();

    assign bus2.req_valid = bus.req_valid;
    assign bus2.wEn       = bus.wEn;
    assign bus2.rEn       = bus.rEn;
    assign bus2.Add       = bus.Add;
    assign bus2.M_valA    = bus.M_valA;

    dmem_pipe #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .err_count (err_count)
    );

    dmem_pipe #(.DATA_W(64), .ADDR_W(64), .DEPTH(DEPTH), .ERR_CNT_W(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus2),
        .init_done (init_done2),
        .err_count (err_count2)
    );

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    bit          exp_ready = 1'b0;
    bit          done = 1'b0;
    logic [63:0] mon_last = '0;
    logic [63:0] exp_m = '0;
    logic [7:0]  exp_c8 = '0;
    logic [1:0]  exp_c2 = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expected responses on their due cycle, otherwise checks idle/hold behaviour.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_dmem_err", 64'(bus.dmem_err), 64'd0);
            chk("rst_m_valM", bus.m_valM, 64'd0);
            chk("rst_err_count", 64'(err_count), 64'd0);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
            chk("rst_init_done", 64'(init_done), 64'd0);
            mon_last = '0;
        end else begin
            chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
            chk("init_done", 64'(init_done), 64'(exp_ready));
            while (q.size() > 0 && q[0].due < cyc) begin
                chk("missed_response", 64'(q[0].due), 64'(cyc));
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
                chk("dmem_err", 64'(bus.dmem_err), 64'(e.err));
                chk("m_valM", bus.m_valM, e.data);
                chk("err_count", 64'(err_count), 64'(e.c8));
                chk("err_count_w2", 64'(err_count2), 64'(e.c2));
                mon_last = e.data;
            end else begin
                chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                chk("idle_dmem_err", 64'(bus.dmem_err), 64'd0);
                chk("hold_m_valM", bus.m_valM, mon_last);
            end
        end
        if (done) begin
            chk("pending_responses", 64'(q.size()), 64'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    // Drives one request for one accept edge; push_rsp=0 marks a response that must never appear.
    task automatic issue(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                         input logic exp_err, input logic [63:0] rd_exp, input bit push_rsp);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.wEn       = w;
        bus.rEn       = r;
        bus.Add       = a;
        bus.M_valA    = d;
        if (push_rsp) begin
            if (exp_err) begin
                exp_m = '0;
                if (exp_c8 != 8'hFF) exp_c8 = exp_c8 + 8'd1;
                if (exp_c2 != 2'b11) exp_c2 = exp_c2 + 2'd1;
            end else if (r) begin
                exp_m = rd_exp;
            end
            e.due  = cyc + 1;
            e.err  = exp_err;
            e.data = exp_m;
            e.c8   = exp_c8;
            e.c2   = exp_c2;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.wEn       = 1'b0;
        bus.rEn       = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        issue(1'b1, 1'b0, a, d, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] exp);
        issue(1'b0, 1'b1, a, 64'd0, 1'b0, exp, 1'b1);
    endtask

    task automatic bad(input logic w, input logic r, input logic [63:0] a);
        issue(w, r, a, 64'h0BAD_0BAD_0BAD_0BAD, 1'b1, 64'd0, 1'b1);
    endtask

    // Releases reset and rides out the 16-cycle clear, poking requests that must be ignored.
    task automatic release_and_clear();
        rst_n = 1'b1;
        exp_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            bus.req_valid = (i < 4);
            bus.rEn       = (i < 4);
            bus.Add       = 64'(i);
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rEn       = 1'b0;
        exp_ready = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.wEn       = 1'b0;
        bus.rEn       = 1'b0;
        bus.Add       = '0;
        bus.M_valA    = '0;
        repeat (3) @(posedge clk);
        #1;
        release_and_clear();

        for (int i = 0; i < int'(DEPTH); i++) rd(64'(i), 64'd0);

        wr(64'd5, 64'h0000_0000_DEAD_BEEF);
        rd(64'd5, 64'h0000_0000_DEAD_BEEF);

        wr(64'd3, 64'h1234_5678_9ABC_DEF0);
        bad(1'b0, 1'b1, 64'd16);
        bad(1'b0, 1'b1, 64'hFFFF_0000_0000_0003);
        rd(64'd3, 64'h1234_5678_9ABC_DEF0);

        bad(1'b1, 1'b1, 64'd3);
        bad(1'b0, 1'b0, 64'd3);
        rd(64'd3, 64'h1234_5678_9ABC_DEF0);

        for (int i = 0; i < 5; i++) bad(1'b0, 1'b1, 64'd100 + 64'(i));
        rd(64'd5, 64'h0000_0000_DEAD_BEEF);

        // Read accepted, then reset lands before its response can be seen.
        wr(64'd9, 64'h0000_0000_0000_0055);
        issue(1'b0, 1'b1, 64'd9, 64'd0, 1'b0, 64'd0, 1'b0);
        rst_n     = 1'b0;
        exp_ready = 1'b0;
        exp_m     = '0;
        exp_c8    = '0;
        exp_c2    = '0;
        repeat (2) @(posedge clk);
        #1;
        release_and_clear();

        rd(64'd9, 64'd0);
        rd(64'd5, 64'd0);
        rd(64'd3, 64'd0);
        bad(1'b0, 1'b1, 64'd20);
        rd(64'd15, 64'd0);

        repeat (2) @(posedge clk);
        #1;
        done = 1'b1;
    end
endmodule
